// File: rtl/tx_frame_arbiter_if.sv
// Request/transmit bundle between the frame sources, the arbiter and the DDR output stage.
// Pure wiring, no latency; req_ready is the per-source backpressure back to the generators.
// Sources hold req_valid until granted; bytes move on req_valid & req_ready.
interface tx_frame_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              tx_en;
    logic [7:0]        tx_data;
    logic [NREQ-1:0]   grant;
    logic              err_underrun;
    logic              err_oversize;

    modport master (
        output req_valid, req_data, req_last,
        input  req_ready, tx_en, tx_data, grant, err_underrun, err_oversize
    );

    modport slave (
        input  req_valid, req_data, req_last,
        output req_ready, tx_en, tx_data, grant, err_underrun, err_oversize
    );
endinterface

// File: rtl/tx_frame_arbiter.sv
// Round-robin sharing of the RGMII tx byte path: preamble, SFD, payload, then inter-frame gap.
// Latency: first preamble byte one cycle after a request is seen; payload bytes one cycle after accept.
// Backpressure: req_ready only to the granted source in PAYLOAD/DRAIN; others hold req_valid until granted.
module tx_frame_arbiter #(
    parameter int NREQ         = 2,
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_LEN      = 12,
    parameter int MAX_LEN      = 1518
) (
    input  logic              clk125,
    input  logic              rst_n,
    tx_frame_arbiter_if.slave bus
);
    localparam int RRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, PAYLOAD, DRAIN, IFG} state_t;

    state_t          state, state_nxt;
    logic [NREQ-1:0] grant, grant_nxt;
    logic [RRW-1:0]  gidx, gidx_nxt;
    logic [RRW-1:0]  rr, rr_nxt;
    logic [4:0]      cnt, cnt_nxt;
    logic [10:0]     byte_cnt, byte_cnt_nxt;
    logic            tx_en, tx_en_nxt;
    logic [7:0]      tx_data, tx_data_nxt;
    logic            err_u, err_u_nxt;
    logic            err_o, err_o_nxt;

    logic            any_req, found;
    logic [RRW-1:0]  win_idx, win_rr;
    int              idx;
    logic            sel_vld, sel_last;
    logic [7:0]      sel_data;

    // Winner is the first requester at or after the rr pointer, wrapping modulo NREQ.
    always_comb begin
        any_req = |bus.req_valid;
        win_idx = rr;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            for (int j = 0; j < NREQ; j++) begin
                if (!found && j == idx && bus.req_valid[j]) begin
                    found   = 1'b1;
                    win_idx = RRW'(j);
                end
            end
        end
        idx = int'(win_idx) + 1;
        if (idx >= NREQ) idx = 0;
        win_rr = RRW'(idx);
    end

    always_comb begin
        sel_vld  = 1'b0;
        sel_last = 1'b0;
        sel_data = 8'h00;
        for (int j = 0; j < NREQ; j++) begin
            if (gidx == RRW'(j)) begin
                sel_vld  = bus.req_valid[j];
                sel_last = bus.req_last[j];
                sel_data = bus.req_data[j*8 +: 8];
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        gidx_nxt     = gidx;
        rr_nxt       = rr;
        cnt_nxt      = cnt;
        byte_cnt_nxt = byte_cnt;
        tx_en_nxt    = tx_en;
        tx_data_nxt  = tx_data;
        err_u_nxt    = 1'b0;
        err_o_nxt    = 1'b0;
        case (state)
            IDLE, IFG: begin
                tx_en_nxt = 1'b0;
                grant_nxt = '0;
                if (state == IFG && cnt != 5'(IFG_LEN)) begin
                    cnt_nxt = cnt + 5'd1;
                end else if (any_req) begin
                    grant_nxt    = NREQ'(1) << win_idx;
                    gidx_nxt     = win_idx;
                    rr_nxt       = win_rr;
                    tx_en_nxt    = 1'b1;
                    tx_data_nxt  = 8'h55;
                    cnt_nxt      = 5'd1;
                    byte_cnt_nxt = '0;
                    state_nxt    = (PREAMBLE_LEN == 1) ? SFD : PREAMBLE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            PREAMBLE: begin
                tx_data_nxt = 8'h55;
                cnt_nxt     = cnt + 5'd1;
                if (cnt == 5'(PREAMBLE_LEN - 1)) state_nxt = SFD;
            end
            SFD: begin
                tx_data_nxt = 8'hD5;
                state_nxt   = PAYLOAD;
            end
            PAYLOAD: begin
                cnt_nxt = '0;
                if (!sel_vld) begin
                    tx_en_nxt = 1'b0;
                    err_u_nxt = 1'b1;
                    state_nxt = DRAIN;
                end else if (byte_cnt == 11'(MAX_LEN)) begin
                    // Byte beyond MAX_LEN is swallowed; the rest of the frame drains silently.
                    tx_en_nxt = 1'b0;
                    err_o_nxt = 1'b1;
                    state_nxt = sel_last ? IFG : DRAIN;
                end else begin
                    tx_en_nxt    = 1'b1;
                    tx_data_nxt  = sel_data;
                    byte_cnt_nxt = byte_cnt + 11'd1;
                    if (sel_last) state_nxt = IFG;
                end
            end
            DRAIN: begin
                tx_en_nxt = 1'b0;
                cnt_nxt   = '0;
                if (sel_vld && sel_last) state_nxt = IFG;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            gidx     <= '0;
            rr       <= '0;
            cnt      <= '0;
            byte_cnt <= '0;
            tx_en    <= 1'b0;
            tx_data  <= 8'h00;
            err_u    <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            gidx     <= gidx_nxt;
            rr       <= rr_nxt;
            cnt      <= cnt_nxt;
            byte_cnt <= byte_cnt_nxt;
            tx_en    <= tx_en_nxt;
            tx_data  <= tx_data_nxt;
            err_u    <= err_u_nxt;
            err_o    <= err_o_nxt;
        end
    end

    assign bus.req_ready    = (state == PAYLOAD || state == DRAIN) ? grant : '0;
    assign bus.tx_en        = tx_en;
    assign bus.tx_data      = tx_data;
    assign bus.grant        = grant;
    assign bus.err_underrun = err_u;
    assign bus.err_oversize = err_o;
endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench for tx_frame_arbiter with four requesters: framing, round robin, gap, errors, reset.
module tb_tx_frame_arbiter;
    localparam int N = 4;

    logic clk;
    logic rst_n;

    tx_frame_arbiter_if #(.NREQ(N)) bus ();

    tx_frame_arbiter #(.NREQ(N)) dut (
        .clk125 (clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #4 clk = ~clk;
    end

    int n_cmp;
    int n_fail;

    // Source model state
    int src_frames [N];
    int src_len    [N];
    int src_pos    [N];
    int src_drop_at[N];
    int src_drop_n [N];

    // Monitor records, one entry per frame seen on tx_en
    int q_len[$];
    int q_grant[$];
    int q_bad[$];
    int q_gap[$];
    int n_under;
    int n_over;
    int mon_pos;
    bit mon_in;

    function automatic logic [7:0] pat(input int i, input int k);
        return 8'((i << 6) + k);
    endfunction

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            src_frames[i]  = 0;
            src_len[i]     = 1;
            src_pos[i]     = 0;
            src_drop_at[i] = -1;
            src_drop_n[i]  = 0;
        end
    endtask

    task automatic clear_q();
        q_len.delete();
        q_grant.delete();
        q_bad.delete();
        q_gap.delete();
    endtask

    // Driver: sample acceptance before the edge, advance after it.
    initial begin
        logic [N-1:0] acc;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        acc           = '0;
        forever begin
            @(negedge clk);
            acc = bus.req_valid & bus.req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                bit drop;
                if (rst_n && acc[i]) begin
                    if (src_pos[i] == src_len[i] - 1) begin
                        src_frames[i]--;
                        src_pos[i] = 0;
                    end else begin
                        src_pos[i]++;
                    end
                end
                drop = (src_frames[i] > 0) && (src_pos[i] == src_drop_at[i]) && (src_drop_n[i] > 0);
                if (drop) src_drop_n[i]--;
                bus.req_valid[i]       = (src_frames[i] > 0) && !drop;
                bus.req_data[i*8 +: 8] = pat(i, src_pos[i]);
                bus.req_last[i]        = (src_pos[i] == src_len[i] - 1);
            end
        end
    end

    // Monitor: frame length, owner, byte errors, preceding gap, error pulses.
    initial begin
        int zeros, cur_grant, cur_bad, cur_gap, gidx;
        bit had;
        logic [7:0] exp;
        zeros = 0; had = 0; mon_in = 0; mon_pos = 0;
        cur_grant = 0; cur_bad = 0; cur_gap = -1; gidx = 0;
        n_under = 0; n_over = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_in = 0; had = 0; zeros = 0; mon_pos = 0;
            end else begin
                if (bus.err_underrun) n_under++;
                if (bus.err_oversize) n_over++;
                if (bus.tx_en) begin
                    if (!mon_in) begin
                        mon_in    = 1;
                        cur_grant = int'(bus.grant);
                        cur_gap   = had ? zeros : -1;
                        cur_bad   = 0;
                        mon_pos   = 0;
                        gidx      = 0;
                        for (int j = 0; j < N; j++) if (bus.grant[j]) gidx = j;
                    end
                    if (mon_pos < 7)       exp = 8'h55;
                    else if (mon_pos == 7) exp = 8'hD5;
                    else                   exp = pat(gidx, mon_pos - 8);
                    if (bus.tx_data !== exp) cur_bad++;
                    mon_pos++;
                end else begin
                    if (mon_in) begin
                        q_len.push_back(mon_pos);
                        q_grant.push_back(cur_grant);
                        q_bad.push_back(cur_bad);
                        q_gap.push_back(cur_gap);
                        mon_in = 0;
                        had    = 1;
                        zeros  = 0;
                    end
                    zeros++;
                end
            end
        end
    end

    task automatic wait_frames(input int n, input int budget, output bit ok);
        ok = 0;
        for (int c = 0; c < budget && q_len.size() < n; c++) @(negedge clk);
        if (q_len.size() >= n) ok = 1;
    endtask

    task automatic wait_src_done(input int budget, output bit ok);
        int left;
        ok = 0;
        for (int c = 0; c < budget; c++) begin
            left = 0;
            for (int i = 0; i < N; i++) left += src_frames[i];
            if (left == 0) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_src();
        clear_q();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        n_cmp++; if (bus.tx_en !== 1'b0) begin n_fail++; $display("FAIL rst_tx_en: got %b want 0", bus.tx_en); end
        n_cmp++; if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %h want 00", bus.tx_data); end
        n_cmp++; if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL rst_grant: got %b want 0000", bus.grant); end
        n_cmp++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_req_ready: got %b want 0000", bus.req_ready); end
        n_cmp++; if ({bus.err_underrun, bus.err_oversize} !== 2'b00) begin
            n_fail++; $display("FAIL rst_err: got %b want 00", {bus.err_underrun, bus.err_oversize});
        end
    endtask

    task automatic test_single_frame();
        bit ok;
        clear_q();
        src_len[0] = 64; src_frames[0] = 1;
        wait_frames(1, 300, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_timeout: frames %0d want 1", q_len.size()); end
        if (ok) begin
            n_cmp++; if (q_len[0] != 72) begin n_fail++; $display("FAIL single_len: got %0d want 72", q_len[0]); end
            n_cmp++; if (q_grant[0] != 1) begin n_fail++; $display("FAIL single_grant: got %0d want 1", q_grant[0]); end
            n_cmp++; if (q_bad[0] != 0) begin n_fail++; $display("FAIL single_bytes: bad %0d want 0", q_bad[0]); end
        end
        n_cmp++; if (src_frames[0] != 0) begin n_fail++; $display("FAIL single_consumed: left %0d want 0", src_frames[0]); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int exp_g [3];
        exp_g = '{1, 2, 1};
        do_reset();
        src_len[0] = 20; src_len[1] = 20;
        src_frames[0] = 2; src_frames[1] = 1;
        wait_frames(3, 400, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_timeout: frames %0d want 3", q_len.size()); end
        if (ok) begin
            for (int f = 0; f < 3; f++) begin
                n_cmp++; if (q_grant[f] != exp_g[f]) begin n_fail++; $display("FAIL b2b_grant%0d: got %0d want %0d", f, q_grant[f], exp_g[f]); end
                n_cmp++; if (q_len[f] != 28 || q_bad[f] != 0) begin
                    n_fail++; $display("FAIL b2b_frame%0d: len %0d bad %0d want len 28 bad 0", f, q_len[f], q_bad[f]);
                end
                if (f > 0) begin
                    n_cmp++; if (q_gap[f] != 12) begin n_fail++; $display("FAIL b2b_gap%0d: got %0d want 12", f, q_gap[f]); end
                end
            end
        end
    endtask

    task automatic test_underrun();
        bit ok;
        int u0, o0;
        clear_q();
        u0 = n_under; o0 = n_over;
        src_len[1] = 30; src_drop_at[1] = 10; src_drop_n[1] = 3; src_frames[1] = 1;
        wait_frames(1, 200, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL under_timeout: frames %0d want 1", q_len.size()); end
        if (ok) begin
            n_cmp++; if (q_len[0] != 18) begin n_fail++; $display("FAIL under_len: got %0d want 18", q_len[0]); end
            n_cmp++; if (q_grant[0] != 2 || q_bad[0] != 0) begin
                n_fail++; $display("FAIL under_frame: grant %0d bad %0d want grant 2 bad 0", q_grant[0], q_bad[0]);
            end
        end
        wait_src_done(200, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL under_drain: left %0d want 0", src_frames[1]); end
        repeat (20) @(negedge clk);
        n_cmp++; if (n_under - u0 != 1) begin n_fail++; $display("FAIL under_pulses: got %0d want 1", n_under - u0); end
        n_cmp++; if (n_over != o0) begin n_fail++; $display("FAIL under_no_over: got %0d want 0", n_over - o0); end
        n_cmp++; if (q_len.size() != 1) begin n_fail++; $display("FAIL under_frames: got %0d want 1", q_len.size()); end
    endtask

    task automatic test_oversize();
        bit ok;
        int lens  [3];
        int pulses[3];
        int o0;
        lens   = '{1600, 1519, 1518};
        pulses = '{1, 1, 0};
        for (int t = 0; t < 3; t++) begin
            clear_q();
            o0 = n_over;
            src_len[0] = lens[t]; src_frames[0] = 1;
            wait_src_done(1800, ok);
            repeat (16) @(negedge clk);
            n_cmp++; if (ok !== 1'b1 || q_len.size() != 1) begin
                n_fail++; $display("FAIL over%0d_done: ok %0d frames %0d want 1 1", lens[t], ok, q_len.size());
            end else begin
                n_cmp++; if (q_len[0] != 1526 || q_bad[0] != 0) begin
                    n_fail++; $display("FAIL over%0d_frame: len %0d bad %0d want len 1526 bad 0", lens[t], q_len[0], q_bad[0]);
                end
            end
            n_cmp++; if (n_over - o0 != pulses[t]) begin
                n_fail++; $display("FAIL over%0d_pulse: got %0d want %0d", lens[t], n_over - o0, pulses[t]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int c;
        src_len[2] = 60; src_frames[2] = 1;
        c = 0;
        while (!(mon_in && mon_pos >= 38) && c < 200) begin
            @(negedge clk);
            c++;
        end
        n_cmp++; if (!(mon_in && mon_pos >= 38)) begin n_fail++; $display("FAIL rstmid_timeout: pos %0d want 38", mon_pos); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.tx_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_tx_en: got %b want 0", bus.tx_en); end
        n_cmp++; if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL rstmid_grant: got %b want 0000", bus.grant); end
        clear_src();
        clear_q();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            src_len[i] = 8;
            src_frames[i] = 2;
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int exp_g [5];
        exp_g = '{1, 2, 4, 8, 1};
        wait_frames(5, 500, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rr_timeout: frames %0d want 5", q_len.size()); end
        if (ok) begin
            for (int f = 0; f < 5; f++) begin
                n_cmp++; if (q_grant[f] != exp_g[f]) begin n_fail++; $display("FAIL rr_grant%0d: got %0d want %0d", f, q_grant[f], exp_g[f]); end
                n_cmp++; if (q_len[f] != 16 || q_bad[f] != 0) begin
                    n_fail++; $display("FAIL rr_frame%0d: len %0d bad %0d want len 16 bad 0", f, q_len[f], q_bad[f]);
                end
                if (f > 0) begin
                    n_cmp++; if (q_gap[f] != 12) begin n_fail++; $display("FAIL rr_gap%0d: got %0d want 12", f, q_gap[f]); end
                end
            end
        end
        wait_src_done(600, ok);
        repeat (4) @(negedge clk);
        n_cmp++; if (ok !== 1'b1 || q_len.size() != 8) begin
            n_fail++; $display("FAIL rr_total: ok %0d frames %0d want 1 8", ok, q_len.size());
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        clear_src();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_underrun();
        test_oversize();
        test_reset_mid_frame();
        test_round_robin();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
